// File: rtl/pbuf_prog_writer.sv
// pbuf_prog_writer: two-phase setup/pulse/hold programming sequencer for a pbuf6 3x2 config store.
// Optional shadow of the last completed pattern is enabled with `define PBUF_PROG_SHADOW_EN.
module pbuf_prog_writer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_data,
    output logic       busy,
    output logic       done,
    output logic       prog_dat0,
    output logic       prog_dat1,
    output logic       prog_dat2,
    output logic       prog_cap0,
    output logic       prog_cap1,
    output logic [5:0] cfg_shadow
);

    // Zero-length phases would break the strobe/data separation, so clamp into the counter range.
    localparam logic [3:0] SETUP_LEN = (SETUP_CYC < 1) ? 4'd1 : (SETUP_CYC > 15) ? 4'd15 : 4'(SETUP_CYC);
    localparam logic [3:0] PULSE_LEN = (PULSE_CYC < 1) ? 4'd1 : (PULSE_CYC > 15) ? 4'd15 : 4'(PULSE_CYC);
    localparam logic [3:0] HOLD_LEN  = (HOLD_CYC  < 1) ? 4'd1 : (HOLD_CYC  > 15) ? 4'd15 : 4'(HOLD_CYC);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_setup_range
        $warning("pbuf_prog_writer: SETUP_CYC=%0d outside 1..15, clamped", SETUP_CYC);
    end
    if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_pulse_range
        $warning("pbuf_prog_writer: PULSE_CYC=%0d outside 1..15, clamped", PULSE_CYC);
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_hold_range
        $warning("pbuf_prog_writer: HOLD_CYC=%0d outside 1..15, clamped", HOLD_CYC);
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP0 = 3'd1,
        ST_PULSE0 = 3'd2,
        ST_HOLD0  = 3'd3,
        ST_SETUP1 = 3'd4,
        ST_PULSE1 = 3'd5,
        ST_HOLD1  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic [5:0] data_r;
    logic [5:0] src_s;
    logic [2:0] dat_s;
    logic       ready_r;
    logic       busy_r;
    logic       done_r;
    logic [2:0] dat_r;
    logic       cap0_r;
    logic       cap1_r;

    // State and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: each timed phase reloads the counter on entry and exits when it reaches zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_s = ST_SETUP0;
                    cnt_s   = SETUP_LEN - 4'd1;
                end else begin
                    cnt_s   = 4'd0;
                end
            end
            ST_SETUP0, ST_SETUP1: begin
                if (cnt_r == 4'd0) begin
                    state_s = (state_r == ST_SETUP0) ? ST_PULSE0 : ST_PULSE1;
                    cnt_s   = PULSE_LEN - 4'd1;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_PULSE0, ST_PULSE1: begin
                if (cnt_r == 4'd0) begin
                    state_s = (state_r == ST_PULSE0) ? ST_HOLD0 : ST_HOLD1;
                    cnt_s   = HOLD_LEN - 4'd1;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_HOLD0: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_SETUP1;
                    cnt_s   = SETUP_LEN - 4'd1;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_HOLD1: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Row data for the coming cycle; on accept the pattern comes straight from cfg_data.
    always_comb begin
        src_s = data_r;
        if (state_r == ST_IDLE) begin
            src_s = cfg_data;
        end else begin
            src_s = data_r;
        end
        dat_s = 3'b000;
        case (state_s)
            ST_SETUP0, ST_PULSE0, ST_HOLD0: dat_s = {src_s[4], src_s[2], src_s[0]};
            ST_SETUP1, ST_PULSE1, ST_HOLD1: dat_s = {src_s[5], src_s[3], src_s[1]};
            default:                        dat_s = 3'b000;
        endcase
    end

    // Pattern capture on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 6'b000000;
        end else if (state_r == ST_IDLE && cfg_valid) begin
            data_r <= cfg_data;
        end
    end

    // Outputs are registered from the next state so they change cleanly with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dat_r   <= 3'b000;
            cap0_r  <= 1'b0;
            cap1_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            dat_r   <= dat_s;
            cap0_r  <= (state_s == ST_PULSE0);
            cap1_r  <= (state_s == ST_PULSE1);
        end
    end

    assign cfg_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign prog_dat0 = dat_r[0];
    assign prog_dat1 = dat_r[1];
    assign prog_dat2 = dat_r[2];
    assign prog_cap0 = cap0_r;
    assign prog_cap1 = cap1_r;

`ifdef PBUF_PROG_SHADOW_EN
    logic [5:0] shadow_r;

    // Shadow copy of the last pattern whose sequence ran to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= 6'b000000;
        end else if (state_r == ST_DONE) begin
            shadow_r <= data_r;
        end
    end

    assign cfg_shadow = shadow_r;
`else
    assign cfg_shadow = 6'b000000;
`endif

endmodule

// File: tb/tb_pbuf_prog_writer.sv
// Self-checking bench for pbuf_prog_writer: default-timing and 3/2/2-timing instances, pbuf6 capture models.
module tb_pbuf_prog_writer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       valid_a, valid_b;
    logic [5:0] data_a, data_b;
    logic       ready_a, busy_a, done_a, dat0_a, dat1_a, dat2_a, cap0_a, cap1_a;
    logic       ready_b, busy_b, done_b, dat0_b, dat1_b, dat2_b, cap0_b, cap1_b;
    logic [5:0] shadow_a, shadow_b;
    logic [7:0] obs_a, obs_b;
    logic [5:0] pb_a, pb_b;
    logic [5:0] exp_shadow [2];
    int checks = 0;
    int errors = 0;

    pbuf_prog_writer dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_valid(valid_a), .cfg_ready(ready_a), .cfg_data(data_a),
        .busy(busy_a), .done(done_a), .prog_dat0(dat0_a), .prog_dat1(dat1_a), .prog_dat2(dat2_a),
        .prog_cap0(cap0_a), .prog_cap1(cap1_a), .cfg_shadow(shadow_a)
    );

    pbuf_prog_writer #(.SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_valid(valid_b), .cfg_ready(ready_b), .cfg_data(data_b),
        .busy(busy_b), .done(done_b), .prog_dat0(dat0_b), .prog_dat1(dat1_b), .prog_dat2(dat2_b),
        .prog_cap0(cap0_b), .prog_cap1(cap1_b), .cfg_shadow(shadow_b)
    );

    assign obs_a = {ready_a, busy_a, done_a, dat2_a, dat1_a, dat0_a, cap1_a, cap0_a};
    assign obs_b = {ready_b, busy_b, done_b, dat2_b, dat1_b, dat0_b, cap1_b, cap0_b};

    // Behavioural pbuf6: each strobe's rising edge captures one column from the three rows.
    always @(posedge cap0_a) begin pb_a[0] <= dat0_a; pb_a[2] <= dat1_a; pb_a[4] <= dat2_a; end
    always @(posedge cap1_a) begin pb_a[1] <= dat0_a; pb_a[3] <= dat1_a; pb_a[5] <= dat2_a; end
    always @(posedge cap0_b) begin pb_b[0] <= dat0_b; pb_b[2] <= dat1_b; pb_b[4] <= dat2_b; end
    always @(posedge cap1_b) begin pb_b[1] <= dat0_b; pb_b[3] <= dat1_b; pb_b[5] <= dat2_b; end

    typedef struct {
        int         which;
        logic [5:0] pat;
        int         exp_lat;
        logic [2:0] exp_d0;
        logic [2:0] exp_d1;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%b exp=%b", name, k, got, exp);
        end
    endtask

    // Expected {ready,busy,done,dat2,dat1,dat0,cap1,cap0} k cycles after the accept edge.
    function automatic logic [7:0] exp_out(input logic [5:0] pat, input int s, input int p, input int h, input int k);
        int t, r;
        logic [2:0] d;
        logic c;
        t = s + p + h;
        if (k == 2 * t) return 8'b0110_0000;
        if (k < t) begin r = k;     d = {pat[4], pat[2], pat[0]}; end
        else       begin r = k - t; d = {pat[5], pat[3], pat[1]}; end
        c = (r >= s) && (r < s + p);
        return {1'b0, 1'b1, 1'b0, d, (k >= t) && c, (k < t) && c};
    endfunction

    task automatic chk_shadow(input int which, input int k);
        chk(which == 0 ? "shadow_a" : "shadow_b", k, {2'b00, (which == 0) ? shadow_a : shadow_b},
            {2'b00, exp_shadow[which]});
    endtask

    // Starts on the falling edge right after the accept edge; ends on the IDLE cycle after done.
    task automatic run_checks(input int which, input logic [5:0] pat, input int inj_k, input logic [5:0] inj_pat,
                              output int got_lat, output logic [2:0] got_d0, output logic [2:0] got_d1);
        int s, p, h, t;
        logic [7:0] got;
        s = (which == 0) ? 1 : 3;
        p = (which == 0) ? 1 : 2;
        h = (which == 0) ? 1 : 2;
        t = s + p + h;
        got_lat = 0;
        got_d0  = 3'b000;
        got_d1  = 3'b000;
        if (which == 0) valid_a = 1'b0; else valid_b = 1'b0;
        for (int k = 0; k <= 2 * t; k++) begin
            got = (which == 0) ? obs_a : obs_b;
            chk(which == 0 ? "out_a" : "out_b", k, got, exp_out(pat, s, p, h, k));
            chk_shadow(which, k);
            if (got[5] && got_lat == 0) got_lat = k + 1;
            if (got[0]) got_d0 = got[4:2];
            if (got[1]) got_d1 = got[4:2];
            if (k == inj_k) begin valid_a = 1'b1; data_a = inj_pat; end
            @(negedge clk);
        end
        got = (which == 0) ? obs_a : obs_b;
        chk("idle_after_done", 2 * t + 1, got, 8'b1000_0000);
`ifdef PBUF_PROG_SHADOW_EN
        exp_shadow[which] = pat;
`endif
        chk_shadow(which, 2 * t + 1);
        chk("pbuf_model", 2 * t + 1, {2'b00, (which == 0) ? pb_a : pb_b}, {2'b00, pat});
    endtask

    task automatic write_seq(input int which, input logic [5:0] pat,
                             output int lat, output logic [2:0] d0, output logic [2:0] d1);
        @(negedge clk);
        if (which == 0) begin valid_a = 1'b1; data_a = pat; end
        else            begin valid_b = 1'b1; data_b = pat; end
        @(negedge clk);
        run_checks(which, pat, -1, 6'b000000, lat, d0, d1);
    endtask

    initial begin
        int lat;
        logic [2:0] d0, d1;
        logic [5:0] rp;

        vecs[0] = '{0, 6'b000001,  7, 3'b001, 3'b000};
        vecs[1] = '{1, 6'b101010, 15, 3'b000, 3'b111};
        vecs[2] = '{0, 6'b111111,  7, 3'b111, 3'b111};
        vecs[3] = '{1, 6'b010101, 15, 3'b111, 3'b000};
        vecs[4] = '{0, 6'b110100,  7, 3'b110, 3'b100};

        rst_n = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = 6'b000000; data_b = 6'b000000;
        exp_shadow[0] = 6'b000000;
        exp_shadow[1] = 6'b000000;
        repeat (3) @(negedge clk);
        chk("in_reset_a", 0, obs_a & 8'h7F, 8'h00);
        chk("in_reset_b", 0, obs_b & 8'h7F, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_a", 0, obs_a, 8'b1000_0000);
        chk("reset_b", 0, obs_b, 8'b1000_0000);
        chk_shadow(0, 0);
        chk_shadow(1, 0);

        for (int i = 0; i < 5; i++) begin
            write_seq(vecs[i].which, vecs[i].pat, lat, d0, d1);
            chk("tbl_latency", i, 8'(lat), 8'(vecs[i].exp_lat));
            chk("tbl_cap0_dat", i, {5'b00000, d0}, {5'b00000, vecs[i].exp_d0});
            chk("tbl_cap1_dat", i, {5'b00000, d1}, {5'b00000, vecs[i].exp_d1});
        end

        // Request raised during PULSE0 must wait for done plus one IDLE cycle.
        @(negedge clk);
        valid_a = 1'b1; data_a = 6'b111111;
        @(negedge clk);
        run_checks(0, 6'b111111, 1, 6'b000000, lat, d0, d1);
        chk("busy_ignore_lat", 0, 8'(lat), 8'd7);
        @(negedge clk);
        run_checks(0, 6'b000000, -1, 6'b000000, lat, d0, d1);

        // Asynchronous reset during PULSE1 clears the strobe before the next clock edge.
        @(negedge clk);
        valid_a = 1'b1; data_a = 6'b010101;
        @(negedge clk);
        valid_a = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            chk("pre_abort", k, obs_a, exp_out(6'b010101, 1, 1, 1, k));
            if (k < 4) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_clear_a", 4, obs_a & 8'h7F, 8'h00);
        chk("async_clear_b", 4, obs_b & 8'h7F, 8'h00);
        exp_shadow[0] = 6'b000000;
        exp_shadow[1] = 6'b000000;
        chk_shadow(0, 4);
        chk_shadow(1, 4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_ready", 0, obs_a, 8'b1000_0000);
        write_seq(0, 6'b010101, lat, d0, d1);
        chk("post_abort_lat", 0, 8'(lat), 8'd7);

        // Shadow picks up this pattern only on the cycle after done.
        write_seq(0, 6'b100000, lat, d0, d1);

        for (int i = 0; i < 16; i++) begin
            rp = 6'($urandom_range(0, 63));
            write_seq(0, rp, lat, d0, d1);
            chk("rand_lat_a", i, 8'(lat), 8'd7);
        end
        for (int i = 0; i < 4; i++) begin
            rp = 6'($urandom_range(0, 63));
            write_seq(1, rp, lat, d0, d1);
            chk("rand_lat_b", i, 8'(lat), 8'd15);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
